serial_add_sequencer: RTL

Bit-serial adder controller. Sequences a single full-adder slice (sum = a^b^c, carry = a&b | c&(a^b)) over WIDTH cycles to add two WIDTH-bit operands. Uses a start/busy/done handshake. Provides a low-area alternative to a parallel adder for operand-accumulation paths, such as adding an offset to the free-running 32-bit count value.

---
 rtl/serial_add_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Start/busy/done handshake; result, carry-out and signed overflow are held until the next completion.
module serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // {carry, sum} of a single full-adder slice
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  always_comb begin
    {slice_c, slice_s} = full_add(a_sr[0], b_sr[0], carry);
    res_next           = {slice_s, res_sr[WIDTH-1:1]};
    last_bit           = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= slice_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry still holds the MSB slice carry-in here, so overflow is cin_msb ^ cout
            sum   <= res_next;
            cout  <= slice_c;
            ovf   <= carry ^ slice_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
